// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: frame layout, line levels and transmitter states shared by the serial bus tx and analyser.
package serial_bus_pkg;
  localparam int SOP_BITS = 1;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 4;
  localparam int EOF_BITS = 2;
  localparam int FRAME_BITS = SOP_BITS + CMD_BITS + ADDR_BITS + EOF_BITS;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {IDLE, SOP, CMD, ADDR, EOF, GAP} tx_state_e;
  function automatic int field_bits(tx_state_e s);
    return s == SOP ? SOP_BITS : s == CMD ? CMD_BITS : s == ADDR ? ADDR_BITS : s == EOF ? EOF_BITS : 0;
  endfunction
  function automatic tx_state_e next_field(tx_state_e s);
    return s == SOP ? CMD : s == CMD ? ADDR : s == ADDR ? EOF : s == EOF ? GAP : IDLE;
  endfunction
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: divides clk by CLKS_PER_BIT into a one-cycle bit tick, realigned by restart.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (restart || cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= RELOAD;
    else cnt_q <= cnt_d;
  assign tick = cnt_q == '0;
  assign tick_next = cnt_d == '0;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes an accepted CMD/ADDR pair as SOP, CMD, ADDR, EOF onto an idle-high line.
module serial_frame_tx
  import serial_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_GAP = 2,
  parameter logic [1:0] EOF_PATTERN = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frm_valid,
  output logic       frm_ready,
  input  logic [7:0] frm_cmd,
  input  logic [3:0] frm_addr,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);
  localparam int BW = IDLE_GAP > 16 ? $clog2(IDLE_GAP) : 4;
  localparam int SW = CMD_BITS + ADDR_BITS;
  tx_state_e state_q, state_d, ns;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] sh_q, sh_d;
  logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic tick, tick_next, accept, last_bit;
  assign accept = frm_valid && ready_q;
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst(rst),
    .restart(accept),
    .tick(tick),
    .tick_next(tick_next)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= GAP;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= IDLE_LEVEL;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  // GAP is left one cycle before its last tick so the registered ready allows an accept exactly when the gap ends.
  always_comb begin
    last_bit = bit_q == BW'(state_q == GAP ? IDLE_GAP - 1 : field_bits(state_q) - 1);
    ns = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    if (accept) begin
      ns = SOP;
      bit_d = '0;
      sh_d = {frm_cmd, frm_addr};
    end else if (tick && state_q != IDLE) begin
      ns = last_bit ? next_field(state_q) : state_q;
      bit_d = last_bit ? '0 : bit_q + BW'(1);
      sh_d = (state_q == CMD || state_q == ADDR) ? sh_q << 1 : sh_q;
    end
    state_d = (ns == GAP && bit_d == BW'(IDLE_GAP - 1) && tick_next) ? IDLE : ns;
  end
  always_comb begin
    tx_d = state_d == SOP ? 1'b0 :
           (state_d == CMD || state_d == ADDR) ? sh_d[SW-1] :
           state_d == EOF ? (bit_d[0] ? EOF_PATTERN[0] : EOF_PATTERN[1]) : IDLE_LEVEL;
    busy_d = state_d inside {SOP, CMD, ADDR, EOF};
    ready_d = state_d == IDLE;
    done_d = state_d == EOF && bit_d == BW'(EOF_BITS - 1) && tick_next;
  end
  assign tx_out = tx_q;
  assign frm_ready = ready_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frame vectors over three configurations plus reset corner sequences.
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] v, rdy, tx, bz, dn;
  logic [7:0] c[3];
  logic [3:0] a[3];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int inst;
    logic [7:0] cmd;
    logic [3:0] addr;
    bit hold;
    bit scr;
    logic [14:0] exp;
    int lead;
  } vec_t;
  always #5 clk = ~clk;
  serial_frame_tx #(.CLKS_PER_BIT(1), .IDLE_GAP(2), .EOF_PATTERN(2'b11)) u0 (
    .clk(clk), .rst(rst), .frm_valid(v[0]), .frm_ready(rdy[0]), .frm_cmd(c[0]), .frm_addr(a[0]),
    .tx_out(tx[0]), .busy(bz[0]), .frame_done(dn[0]));
  serial_frame_tx #(.CLKS_PER_BIT(4), .IDLE_GAP(2), .EOF_PATTERN(2'b11)) u1 (
    .clk(clk), .rst(rst), .frm_valid(v[1]), .frm_ready(rdy[1]), .frm_cmd(c[1]), .frm_addr(a[1]),
    .tx_out(tx[1]), .busy(bz[1]), .frame_done(dn[1]));
  serial_frame_tx #(.CLKS_PER_BIT(1), .IDLE_GAP(2), .EOF_PATTERN(2'b00)) u2 (
    .clk(clk), .rst(rst), .frm_valid(v[2]), .frm_ready(rdy[2]), .frm_cmd(c[2]), .frm_addr(a[2]),
    .tx_out(tx[2]), .busy(bz[2]), .frame_done(dn[2]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Entered at a negedge; lead counts idle-high samples before the SOP sample.
  task automatic frame(input int i, input logic [7:0] cmd, input logic [3:0] addr,
                       input bit hold, input bit scr, output logic [14:0] got, output int lead);
    int p;
    p = i == 1 ? 4 : 1;
    got = '0;
    lead = 0;
    c[i] = cmd;
    a[i] = addr;
    v[i] = 1'b1;
    while (tx[i] === 1'b1 && lead < 400) begin
      chk($sformatf("idle_busy%0d", i), bz[i], 0);
      @(negedge clk);
      lead++;
    end
    if (lead >= 400) begin
      chk($sformatf("sop_timeout%0d", i), 0, 1);
      v[i] = 1'b0;
      return;
    end
    if (!hold) v[i] = 1'b0;
    for (int j = 0; j < 15 * p; j++) begin
      if (j % p == 0) got[14 - j / p] = tx[i];
      else chk($sformatf("bit_stable%0d_c%0d", i, j), tx[i], got[14 - j / p]);
      chk($sformatf("busy%0d_c%0d", i, j), bz[i], 1);
      chk($sformatf("done%0d_c%0d", i, j), dn[i], j == 15 * p - 1);
      chk($sformatf("ready_low%0d_c%0d", i, j), rdy[i], 0);
      if (scr) begin
        c[i] = 8'($urandom);
        a[i] = 4'($urandom);
      end
      @(negedge clk);
    end
    chk($sformatf("gap_tx%0d", i), tx[i], 1);
    chk($sformatf("gap_busy%0d", i), bz[i], 0);
    chk($sformatf("gap_done%0d", i), dn[i], 0);
  endtask
  initial begin
    vec_t tv[9];
    logic [14:0] got;
    int lead;
    tv[0] = '{1, 8'h3C, 4'h9, 1, 0, 15'b0_00111100_1001_11, 8};
    tv[1] = '{1, 8'h3C, 4'h9, 0, 0, 15'b0_00111100_1001_11, 8};
    tv[2] = '{0, 8'hA5, 4'h3, 0, 0, 15'b0_10100101_0011_11, 1};
    tv[3] = '{0, 8'hFF, 4'hF, 1, 0, 15'b0_11111111_1111_11, 2};
    tv[4] = '{0, 8'h00, 4'h0, 1, 0, 15'b0_00000000_0000_11, 2};
    tv[5] = '{0, 8'h81, 4'h8, 0, 0, 15'b0_10000001_1000_11, 2};
    tv[6] = '{0, 8'h5A, 4'h6, 0, 1, 15'b0_01011010_0110_11, 2};
    tv[7] = '{2, 8'hC3, 4'h5, 1, 0, 15'b0_11000011_0101_00, 1};
    tv[8] = '{2, 8'h0F, 4'hA, 0, 0, 15'b0_00001111_1010_00, 2};
    v = '0;
    for (int i = 0; i < 3; i++) begin
      c[i] = '0;
      a[i] = '0;
    end
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx%0d", i), tx[i], 1);
      chk($sformatf("rst_ready%0d", i), rdy[i], 0);
      chk($sformatf("rst_busy%0d", i), bz[i], 0);
      chk($sformatf("rst_done%0d", i), dn[i], 0);
    end
    repeat (3) @(negedge clk);
    v[1] = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      frame(tv[k].inst, tv[k].cmd, tv[k].addr, tv[k].hold, tv[k].scr, got, lead);
      chk($sformatf("frame_row%0d", k), got, tv[k].exp);
      chk($sformatf("lead_row%0d", k), lead, tv[k].lead);
    end
    v[0] = 1'b1;
    c[0] = 8'hE7;
    a[0] = 4'h2;
    for (int n = 0; n < 50 && tx[0] !== 1'b0; n++) @(negedge clk);
    chk("mid_sop", tx[0], 0);
    v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_cmd_bit3", tx[0], 0);
    chk("mid_busy", bz[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_tx", tx[0], 1);
    chk("abort_busy", bz[0], 0);
    chk("abort_ready", rdy[0], 0);
    chk("abort_done", dn[0], 0);
    repeat (2) @(negedge clk);
    chk("abort_hold_tx", tx[0], 1);
    rst = 1'b0;
    frame(0, 8'h4B, 4'hD, 0, 0, got, lead);
    chk("post_abort_frame", got, 15'b0_01001011_1101_11);
    chk("post_abort_lead", lead, 2);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
